// File: rtl/round_robin_arbiter_pkg.sv
// Shared helpers for the round-robin arbiter slice.
package round_robin_arbiter_pkg;

  localparam int RR_MAX_AGENTS = 32;

  // Modulo-n increment; keeps the pointer legal for non-power-of-two agent counts.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority pick: first requester at or after ptr_i wins.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         onehot_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);
  localparam int PW = $clog2(N);

  always_comb begin
    int j;
    logic [PW-1:0] k;
    j        = 0;
    k        = '0;
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    // Visit agents ptr, ptr+1, ... with manual wrap so any N in 2..32 works.
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      k = PW'(j);
      if (!valid_o && req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = k;
      end
    end
    if (valid_o) onehot_o = N'(1) << idx_o;
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// N-agent round-robin arbiter with registered one-hot grant and rotating priority pointer.
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int NumOfAgents = 4
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic [NumOfAgents-1:0] In,
  output logic [NumOfAgents-1:0] Grant
);
  localparam int PW = $clog2(NumOfAgents);

  logic [NumOfAgents-1:0] grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NumOfAgents-1:0] win_onehot;
  logic [PW-1:0]          win_idx;
  logic                   win_valid;

  rr_priority_pick #(.N(NumOfAgents)) u_pick (
    .req_i    (In),
    .ptr_i    (ptr_q),
    .onehot_o (win_onehot),
    .idx_o    (win_idx),
    .valid_o  (win_valid)
  );

  // Winner drops to lowest priority; an idle cycle leaves the pointer alone.
  always_comb begin
    grant_d = win_onehot;
    ptr_d   = ptr_q;
    if (win_valid) ptr_d = PW'(rr_next(int'(win_idx), NumOfAgents));
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Grant = grant_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants, a monitor pops and checks each cycle.
module tb_round_robin_arbiter;
  localparam int N = 4;

  typedef struct {
    logic         rstb;
    logic [N-1:0] in;
    logic [N-1:0] exp;
  } item_t;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic [N-1:0] In = '0;
  logic [N-1:0] Grant;

  item_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    stim_done = 1'b0;
  int    m_ptr = 0;
  int    wait_cnt[N];

  round_robin_arbiter #(.NumOfAgents(N)) dut (
    .clk   (clk),
    .rstb  (rstb),
    .In    (In),
    .Grant (Grant)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [N-1:0] req, input logic [N-1:0] exp);
    item_t it;
    @(negedge clk);
    rstb = r;
    In   = req;
    it.rstb = r; it.in = req; it.exp = exp;
    exp_q.push_back(it);
  endtask

  // Reference arbitration used only for the random phase.
  function automatic logic [N-1:0] model_pick(input logic [N-1:0] req);
    logic [N-1:0] g;
    int j;
    g = '0;
    for (int i = 0; i < N; i++) begin
      j = (m_ptr + i) % N;
      if (g == '0 && req[j]) begin
        g[j]  = 1'b1;
        m_ptr = (j + 1) % N;
      end
    end
    return g;
  endfunction

  // Monitor: one output per clock, compared #1 after the edge.
  initial begin
    item_t it;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        it = exp_q.pop_front();
        n_tests++;
        if (Grant !== it.exp) begin
          n_fail++;
          $display("FAIL grant: in=%b rstb=%b got=%b expected=%b", it.in, it.rstb, Grant, it.exp);
        end
        n_tests++;
        if (!$onehot0(Grant) || ((Grant & ~it.in) != '0)) begin
          n_fail++;
          $display("FAIL legality: in=%b got=%b required onehot0 subset of in", it.in, Grant);
        end
        for (int i = 0; i < N; i++) begin
          if (!it.rstb || !it.in[i] || Grant[i]) wait_cnt[i] = 0;
          else wait_cnt[i]++;
          if (wait_cnt[i] >= N) begin
            n_tests++;
            n_fail++;
            $display("FAIL starvation: agent %0d waited %0d cycles, limit %0d", i, wait_cnt[i], N - 1);
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r, g;
    int guard;
    // Reset with all requesting, then rotation from agent 0.
    repeat (5) step(1'b0, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b0001);
    step(1'b1, 4'b1111, 4'b0010);
    step(1'b1, 4'b1111, 4'b0100);
    step(1'b1, 4'b1111, 4'b1000);
    step(1'b1, 4'b1111, 4'b0001);  // ptr=1
    step(1'b1, 4'b0000, 4'b0000);
    repeat (3) step(1'b1, 4'b0100, 4'b0100);  // ptr=3
    step(1'b1, 4'b0010, 4'b0010);  // ptr=2
    step(1'b1, 4'b0011, 4'b0001);  // wrap to agent 0
    step(1'b1, 4'b0010, 4'b0010);
    step(1'b1, 4'b1000, 4'b1000);  // ptr wraps to 0
    step(1'b1, 4'b1001, 4'b0001);
    step(1'b1, 4'b1001, 4'b1000);  // ptr=0
    step(1'b1, 4'b0110, 4'b0010);  // ptr=2
    step(1'b1, 4'b0000, 4'b0000);  // ptr must hold at 2
    step(1'b1, 4'b0110, 4'b0100);  // ptr=3
    // Mid-operation reset must discard ptr=3.
    step(1'b0, 4'b1111, 4'b0000);
    step(1'b0, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b0001);
    step(1'b1, 4'b0000, 4'b0000);
    // Random phase from a clean reset.
    step(1'b0, 4'b0000, 4'b0000);
    m_ptr = 0;
    r = N'($urandom_range(0, 15));
    for (int c = 0; c < 24; c++) begin
      g = model_pick(r);
      step(1'b1, r, g);
      for (int i = 0; i < N; i++)
        if (g[i] || !r[i]) r[i] = 1'($urandom_range(0, 1));
    end
    guard = 0;
    while (r != '0 && guard < 16) begin
      g = model_pick(r);
      step(1'b1, r, g);
      r = r & ~g;
      guard++;
    end
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    wait (stim_done);
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d items left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
